conv_channel_scheduler: RTL
===========================

// Module: conv_channel_scheduler
// PURPOSE
//  Sequences the conv core + 256-bit fmap capture pair over several output channels per PS command.
//  Per channel: clear capture, pulse conv start, await conv done and BRAM write done, then advance.
//  Also offsets capture BRAM write addresses by a per-channel base. Watchdog guards hangs.
//  Sits between the PS control registers and the conv/capture datapath, on the stream clock.
// PARAMETERS
//  NUM_CH     4        max channels per command (1..15)
//  ADDR_W     12       local BRAM address width
//  CH_STRIDE  12'h018  BRAM words reserved per channel (24 columns)
//  TIMEOUT    65535    max cycles in WAIT_CONV or WAIT_WRITE before error
// PORTS
//  clk            in   1       clock (single clock domain)
//  rst            in   1       synchronous reset, active-high
//  cmd_start      in   1       PS start pulse; sampled only in IDLE
//  cmd_num_ch     in   4       channel count, latched on accepted cmd_start
//  cmd_abort      in   1       abort; highest priority after rst
//  busy           out  1       high from accept until FINISH/abort
//  done           out  1       1-cycle pulse when all channels written
//  err_cfg        out  1       1-cycle pulse: cmd_num_ch==0 or >NUM_CH
//  err_timeout    out  1       sticky; set on watchdog expiry
//  ch_idx         out  4       current channel index
//  cap_clear      out  1       1-cycle pulse resetting capture before each channel
//  conv_start     out  1       1-cycle pulse to conv core
//  conv_done      in   1       conv core done (level or pulse)
//  cap_write_done in   1       capture BRAM write done (level or pulse)
//  cap_addr_in    in   ADDR_W  capture-generated BRAM address
//  bram_addr_out  out  ADDR_W  cap_addr_in + ch_base, mod 2^ADDR_W (combinational)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, err_cfg, err_timeout, cap_clear, conv_start = 0; ch_idx=0; ch_base=0.
//  Control outputs are registered. Each 1-cycle pulse spans exactly one cycle.
//  Per-state requirements:
//   - IDLE: cmd_start with 1<=cmd_num_ch<=NUM_CH latches n, clears ch_idx/ch_base/err_timeout -> CLEAR.
//     Illegal count: err_cfg pulse next cycle; stay IDLE.
//   - CLEAR: cap_clear=1 for one cycle -> LAUNCH.
//   - LAUNCH: conv_start=1 for one cycle; watchdog=0 -> WAIT_CONV.
//   - WAIT_CONV: conv_done=1 -> WAIT_WRITE. conv_done and cap_write_done both 1 in the same cycle -> NEXT.
//   - WAIT_WRITE: watchdog=0 on entry; cap_write_done=1 -> NEXT.
//   - NEXT: ch_idx==n-1 -> FINISH. Otherwise ch_idx++, ch_base+=CH_STRIDE (wraps mod 2^ADDR_W) -> CLEAR.
//   - FINISH: done=1 for one cycle; busy=0 from the same cycle -> IDLE.
//   - ERROR: watchdog reached TIMEOUT in a wait state; err_timeout=1, busy=1; hold until cmd_abort.
//  Latency: cmd_start at cycle T -> cap_clear at T+1, conv_start at T+2.
//  Inter-channel gap: handshake cycle -> NEXT -> CLEAR -> LAUNCH. That is 3 cycles to the next conv_start.
//  Ignored inputs:
//   - conv_done/cap_write_done outside their wait states.
//   - cmd_start while busy.
//   - Done inputs seen before conv_start are not remembered.
//  cmd_abort in any state -> IDLE next cycle:
//   - busy=0; no done pulse; err_timeout cleared.
//   - ch_idx and ch_base hold their values for debug.
//  rst mid-operation: immediate return to reset values; no pulse emitted.
//  Watchdog counts saturate; it is only active in WAIT_CONV/WAIT_WRITE.
// TESTING
//  1. NUM_CH=4, cmd_num_ch=3; done 5 cycles after each conv_start; write_done 10 cycles after each conv_start
//     -> 3 conv_start pulses; ch_idx 0,1,2; bram_addr_out offset 0x000/0x018/0x030; one done; busy falls with done.
//  2. cmd_num_ch=0, then cmd_num_ch=5 -> err_cfg pulse each time; busy stays 0; no conv_start.
//  3. conv_done and cap_write_done asserted in the same cycle -> next conv_start exactly 3 cycles later.
//  4. TIMEOUT=20; conv_done never asserted -> err_timeout rises 20 cycles after entering WAIT_CONV; busy held;
//     cmd_abort -> busy=0 and err_timeout=0 next cycle.
//  5. cmd_start pulsed during channel 1 -> ignored; run completes normally with a single done pulse.
//  6. rst asserted while in WAIT_WRITE of channel 2 -> all outputs at reset values the next cycle;
//     a new cmd_start then restarts from ch_idx=0.

Source files
------------

// File: rtl/conv_channel_scheduler.sv
// conv_channel_scheduler
// Steps the conv core and the fmap capture unit through a PS-requested number of
// output channels. Each channel gets a capture clear, a conv start pulse, and then
// waits for both conv completion and the capture BRAM write. Capture addresses are
// shifted by a per-channel base so every channel lands in its own BRAM slice.
// A watchdog parks the block in an error state if a wait never resolves.
module conv_channel_scheduler #(
  parameter int                NUM_CH    = 4,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] CH_STRIDE = 'h018,
  parameter int                TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic [3:0]        cmd_num_ch,
  input  logic              cmd_abort,
  output logic              busy,
  output logic              done,
  output logic              err_cfg,
  output logic              err_timeout,
  output logic [3:0]        ch_idx,
  output logic              cap_clear,
  output logic              conv_start,
  input  logic              conv_done,
  input  logic              cap_write_done,
  input  logic [ADDR_W-1:0] cap_addr_in,
  output logic [ADDR_W-1:0] bram_addr_out
);

  localparam int             WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  localparam logic [3:0]     MAX_CH = 4'(NUM_CH);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LAUNCH,
    WAIT_CONV,
    WAIT_WRITE,
    NEXT,
    FINISH,
    ERROR
  } state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic              errCfg_q;
  logic              errTimeout_q;
  logic              capClear_q;
  logic              convStart_q;
  logic [3:0]        chIdx_q;
  logic [3:0]        numCh_q;
  logic [ADDR_W-1:0] chBase_q;
  logic [WD_W-1:0]   wdog_q;
  logic [WD_W-1:0]   wdog_d;
  logic              cmdLegal;

  assign busy          = busy_q;
  assign done          = done_q;
  assign err_cfg       = errCfg_q;
  assign err_timeout   = errTimeout_q;
  assign ch_idx        = chIdx_q;
  assign cap_clear     = capClear_q;
  assign conv_start    = convStart_q;
  assign bram_addr_out = cap_addr_in + chBase_q;

  assign cmdLegal = (cmd_num_ch != 4'd0) && (cmd_num_ch <= MAX_CH);

  // Saturating next value of the watchdog so it can never wrap back to zero
  always_comb begin
    wdog_d = wdog_q;
    if (wdog_q != WD_MAX) begin
      wdog_d = wdog_q + WD_W'(1);
    end
  end

  // Channel sequencer: pulses are cleared every cycle and re-raised only on the transition that owns them
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      errCfg_q     <= 1'b0;
      errTimeout_q <= 1'b0;
      capClear_q   <= 1'b0;
      convStart_q  <= 1'b0;
      chIdx_q      <= 4'd0;
      numCh_q      <= 4'd0;
      chBase_q     <= '0;
      wdog_q       <= '0;
    end else begin
      done_q      <= 1'b0;
      errCfg_q    <= 1'b0;
      capClear_q  <= 1'b0;
      convStart_q <= 1'b0;
      if (cmd_abort) begin
        state_q      <= IDLE;
        busy_q       <= 1'b0;
        errTimeout_q <= 1'b0;
        wdog_q       <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cmd_start) begin
              if (cmdLegal) begin
                numCh_q      <= cmd_num_ch;
                chIdx_q      <= 4'd0;
                chBase_q     <= '0;
                errTimeout_q <= 1'b0;
                busy_q       <= 1'b1;
                capClear_q   <= 1'b1;
                state_q      <= CLEAR;
              end else begin
                errCfg_q <= 1'b1;
              end
            end
          end
          CLEAR: begin
            convStart_q <= 1'b1;
            state_q     <= LAUNCH;
          end
          LAUNCH: begin
            wdog_q  <= '0;
            state_q <= WAIT_CONV;
          end
          WAIT_CONV: begin
            if (conv_done && cap_write_done) begin
              state_q <= NEXT;
            end else if (conv_done) begin
              wdog_q  <= '0;
              state_q <= WAIT_WRITE;
            end else begin
              wdog_q <= wdog_d;
              if (wdog_d == WD_MAX) begin
                errTimeout_q <= 1'b1;
                state_q      <= ERROR;
              end
            end
          end
          WAIT_WRITE: begin
            if (cap_write_done) begin
              state_q <= NEXT;
            end else begin
              wdog_q <= wdog_d;
              if (wdog_d == WD_MAX) begin
                errTimeout_q <= 1'b1;
                state_q      <= ERROR;
              end
            end
          end
          NEXT: begin
            if (chIdx_q == numCh_q - 4'd1) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FINISH;
            end else begin
              chIdx_q    <= chIdx_q + 4'd1;
              chBase_q   <= chBase_q + CH_STRIDE;
              capClear_q <= 1'b1;
              state_q    <= CLEAR;
            end
          end
          FINISH: begin
            state_q <= IDLE;
          end
          ERROR: begin
            busy_q       <= 1'b1;
            errTimeout_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
